datapath_mc: RTL and testbench
==============================

# datapath_mc

Multicycle successor to the single-cycle MIPS-subset datapath. It executes one instruction over 3–5 states, driven by an internal control FSM. Instruction and data accesses share one external memory port that uses a request/ready handshake, so any memory latency is tolerated. It adds reset, `addi`, `j`, a halt state and retire/debug outputs, and sits as the CPU core between the top level and a unified memory.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `ADDR_W`, 32: width of `mem_addr`. Carries the low `ADDR_W` bits of the internal 32-bit byte address. Range 3..32.
- `Clk` in 1: single clock. All state updates on the rising edge.
- `Rst_n` in 1: asynchronous, active-low reset.
- `mem_req` out 1: memory access request.
- `mem_we` out 1: 1 = write (`sw`), 0 = read (fetch or `lw`).
- `mem_addr` out `ADDR_W`: byte address, word-aligned by construction of the PC and ALU results. No alignment check is made.
- `mem_wdata` out 32: store data.
- `mem_rdata` in 32: read data, valid in the cycle `mem_ready`=1.
- `mem_ready` in 1: completes the pending request. Ignored while `mem_req`=0.
- `halted` out 1: core is in HALT.
- `retire` out 1: one-cycle pulse when an instruction completes.
- `pc_out` out 32: current PC register.

## Operation
- Architectural state:
  - PC (32 bits).
  - 32×32 register file. r0 reads 0, and writes to r0 are discarded.
- Internal registers: IR, A, B, ALUOut, MDR, FSM state.
- Supported opcodes:
  - R-type 0x00, with funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A.
  - `lw` 0x23, `sw` 0x2B, `beq` 0x04, `addi` 0x08, `j` 0x02.
- FETCH:
  - Drives `mem_req`=1, `mem_we`=0, `mem_addr`=PC.
  - Stays in FETCH until `mem_ready`=1.
  - On that cycle: IR←`mem_rdata`, PC←PC+4, go to DECODE.
- DECODE:
  - A←R[rs], B←R[rt].
  - Unsupported opcode, or R-type with unsupported funct: go to HALT.
  - Otherwise go to EXEC.
- EXEC:
  - R-type: ALUOut←A op B, then WB.
  - `addi`: ALUOut←A+sext(imm16), then WB.
  - `lw`/`sw`: ALUOut←A+sext(imm16), then MEM.
  - `beq`: if A==B, PC←PC+(sext(imm16)<<2). Then FETCH with a `retire` pulse.
  - `j`: PC←{PC[31:28], imm26, 2'b00}. Then FETCH with a `retire` pulse.
- MEM:
  - Drives `mem_req`=1 and `mem_addr`=ALUOut[ADDR_W-1:0].
  - For `sw`: `mem_we`=1, `mem_wdata`=B.
  - Waits for `mem_ready`. On ready:
    - `sw`: go to FETCH with a `retire` pulse.
    - `lw`: MDR←`mem_rdata`, go to WB.
- WB:
  - R-type writes R[rd]←ALUOut.
  - `addi` writes R[rt]←ALUOut.
  - `lw` writes R[rt]←MDR.
  - Then go to FETCH. `retire`=1 during WB.
- HALT: absorbing. `halted`=1, `mem_req`=0. Only reset leaves HALT.
- Arithmetic rules:
  - add, sub and addi wrap modulo 2^32. There is no overflow trap.
  - slt is a signed compare and writes 0 or 1.
  - sext extends bit 15 to 32 bits.

## Timing
- Reset (asynchronous assert, synchronous-to-`Clk` release):
  - PC=`RESET_PC`, all registers cleared to 0, IR/A/B/ALUOut/MDR=0, state=FETCH.
  - `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `retire`=0, `halted`=0.
- `mem_req` is combinational from state. It is 1 in the first FETCH cycle after reset release.
- Handshake:
  - `mem_addr`, `mem_we` and `mem_wdata` stay stable while `mem_req`=1 and `mem_ready`=0.
  - A transfer completes on the edge where `mem_req`=`mem_ready`=1.
  - `mem_ready` held high gives zero wait states.
- Cycles per instruction with zero wait states:
  - R-type and `addi`: 4.
  - `lw`: 5.
  - `sw`: 4.
  - `beq` and `j`: 3.
- Each wait cycle adds 1 to the count.
- Reset during a pending request drops `mem_req` immediately. The memory must discard the abandoned access.
- `retire` is asserted on the final cycle of the instruction. The new PC is visible on `pc_out` the cycle after.
- PC+4 wraps at 2^32.

## Test plan
- Reset then fetch: `RESET_PC`=0x40, memory returns `addi r1,r0,5` (0x20010005) with `mem_ready` always 1.
  - First request has addr 0x40.
  - After 4 cycles R1=5, `retire` pulses once, `pc_out`=0x44.
- Wait states: same program with `mem_ready` low for 3 cycles on the fetch.
  - `mem_addr` is stable across all wait cycles.
  - The instruction retires 7 cycles after reset release.
- Load/store: R2=0x100, R3=0xDEADBEEF.
  - `sw r3,8(r2)` gives a write request with addr 0x108 and data 0xDEADBEEF.
  - `lw r4,8(r2)`, with the memory model returning stored data, gives R4=0xDEADBEEF in 5 cycles.
- Branch and jump:
  - `beq r0,r0,-1` at 0x10 gives next fetch addr 0x10.
  - `j 0x40` (0x08000040) gives next fetch addr 0x100.
  - `beq` with unequal operands falls through to PC+4.
- ALU edges:
  - 0x7FFFFFFF+1 gives 0x80000000.
  - slt of 0xFFFFFFFF against 1 gives 1.
  - `add r0,r1,r1` leaves r0=0.
- Halt and reset: opcode 0x3F gives `halted`=1 after DECODE, with no further `mem_req`. Asserting `Rst_n`=0 mid-MEM clears `mem_req` combinationally and restarts from `RESET_PC`.

Source files
------------

// File: rtl/datapath_mc.sv
// datapath_mc: multicycle MIPS-subset core with a single shared memory port.
// One instruction takes 3..5 states plus any memory wait cycles. Instruction
// and data accesses use the same request/ready handshake.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_FETCH  | request word at PC; on ready latch IR, PC <= PC+4
// S_DECODE | latch A/B from register file, trap unsupported encodings
// S_EXEC   | ALU op / address calc; beq and j finish here
// S_MEM    | data access at ALUOut; sw finishes here, lw latches MDR
// S_WB     | register file write-back; R-type, addi, lw finish here
// S_HALT   | absorbing stop state, left only through reset
module datapath_mc #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic              Clk,
  input  logic              Rst_n,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic              halted,
  output logic              retire,
  output logic [31:0]       pc_out
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] alu_q, alu_d;
  logic [31:0] mdr_q, mdr_d;
  logic [31:0] rf_q [32];

  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs_idx;
  logic [4:0]  rt_idx;
  logic [4:0]  rd_idx;
  logic [31:0] imm_sext;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        is_sw;
  logic [31:0] addr_full;

  assign opcode   = ir_q[31:26];
  assign rs_idx   = ir_q[25:21];
  assign rt_idx   = ir_q[20:16];
  assign rd_idx   = ir_q[15:11];
  assign funct    = ir_q[5:0];
  assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};
  assign is_sw    = (opcode == OP_SW);

  // r0 is hard-wired to zero on the read side as well as discarded on write
  assign rs_val = (rs_idx == 5'd0) ? 32'd0 : rf_q[rs_idx];
  assign rt_val = (rt_idx == 5'd0) ? 32'd0 : rf_q[rt_idx];

  function automatic logic insn_supported(input logic [5:0] op, input logic [5:0] fn);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_RTYPE: ok = (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
                     (fn == FN_OR)  || (fn == FN_SLT);
      OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [31:0] alu_rtype(input logic [5:0] fn,
                                            input logic [31:0] x,
                                            input logic [31:0] y);
    logic [31:0] r;
    case (fn)
      FN_ADD:  r = x + y;
      FN_SUB:  r = x - y;
      FN_AND:  r = x & y;
      FN_OR:   r = x | y;
      FN_SLT:  r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // next-state and datapath register updates for the control FSM
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    alu_d    = alu_q;
    mdr_d    = mdr_q;
    rf_we    = 1'b0;
    rf_waddr = 5'd0;
    rf_wdata = 32'd0;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + 32'd4;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d     = rs_val;
        b_d     = rt_val;
        state_d = insn_supported(opcode, funct) ? S_EXEC : S_HALT;
      end
      S_EXEC: begin
        case (opcode)
          OP_RTYPE: begin
            alu_d   = alu_rtype(funct, a_q, b_q);
            state_d = S_WB;
          end
          OP_ADDI: begin
            alu_d   = a_q + imm_sext;
            state_d = S_WB;
          end
          OP_LW, OP_SW: begin
            alu_d   = a_q + imm_sext;
            state_d = S_MEM;
          end
          OP_BEQ: begin
            if (a_q == b_q) pc_d = pc_q + {imm_sext[29:0], 2'b00};
            state_d = S_FETCH;
          end
          OP_J: begin
            pc_d    = {pc_q[31:28], ir_q[25:0], 2'b00};
            state_d = S_FETCH;
          end
          default: state_d = S_HALT;
        endcase
      end
      S_MEM: begin
        if (mem_ready) begin
          if (is_sw) begin
            state_d = S_FETCH;
          end else begin
            mdr_d   = mem_rdata;
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        if (opcode == OP_RTYPE) begin
          rf_waddr = rd_idx;
          rf_wdata = alu_q;
        end else if (opcode == OP_LW) begin
          rf_waddr = rt_idx;
          rf_wdata = mdr_q;
        end else begin
          rf_waddr = rt_idx;
          rf_wdata = alu_q;
        end
        rf_we   = (rf_waddr != 5'd0);
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  // state, datapath registers and register file
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= 32'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      alu_q   <= 32'd0;
      mdr_q   <= 32'd0;
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      alu_q   <= alu_d;
      mdr_q   <= mdr_d;
      if (rf_we) rf_q[rf_waddr] <= rf_wdata;
    end
  end

  // memory port: gated by Rst_n so a reset abandons a pending request at once;
  // address/data are zero whenever no request is outstanding
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    addr_full = 32'd0;
    mem_wdata = 32'd0;
    if (Rst_n) begin
      if (state_q == S_FETCH) begin
        mem_req   = 1'b1;
        addr_full = pc_q;
      end else if (state_q == S_MEM) begin
        mem_req   = 1'b1;
        addr_full = alu_q;
        if (is_sw) begin
          mem_we    = 1'b1;
          mem_wdata = b_q;
        end
      end
    end
  end

  assign mem_addr = addr_full[ADDR_W-1:0];

  // retire marks the last cycle of every instruction
  assign retire = (state_q == S_WB) ||
                  ((state_q == S_EXEC) && ((opcode == OP_BEQ) || (opcode == OP_J))) ||
                  ((state_q == S_MEM) && is_sw && mem_ready);

  assign halted = (state_q == S_HALT);
  assign pc_out = pc_q;

endmodule

// File: tb/tb_datapath_mc.sv
// tb_datapath_mc: directed programs from the test plan plus random forward-only
// programs, checked against an instruction-level reference model.
module tb_datapath_mc;

  localparam logic [31:0] RST_PC = 32'h0000_0040;
  localparam logic [31:0] HALT_W = 32'hFC00_0000;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        halted;
  logic        retire;
  logic [31:0] pc_out;

  initial forever #5 Clk = ~Clk;

  datapath_mc #(.RESET_PC(RST_PC), .ADDR_W(32)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .halted(halted), .retire(retire), .pc_out(pc_out)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
  endtask

  // memory seen by the DUT and the reference model's own copy
  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];

  // reference architectural state
  logic [31:0] m_pc;
  logic [31:0] m_rf [32];

  int  wait_pct = 0;
  int  force_wait = 0;
  int  fw_left = 0;
  bit  hold_wr = 1'b0;

  int  cyc, wcyc, n_ret, last_ret_cyc, req_in_halt;
  bit  pc_pend;
  logic [31:0] pc_exp;
  bit  prev_wait;
  logic [31:0] prev_addr, prev_wdata;
  logic prev_we;
  bit  got_first;
  logic [31:0] first_req_addr;
  logic [31:0] last_wr_addr, last_wr_data;
  int  st_base;
  bit  st_sw;
  logic [31:0] st_wa, st_wd;

  function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [4:0] rt);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rt,
                                        input logic [4:0] rs, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [25:0] tgt);
    return {6'h02, tgt};
  endfunction

  // executes one instruction of the reference model; returns its base cycle count
  task automatic model_step(output int base, output bit is_sw,
                            output logic [31:0] wa, output logic [31:0] wd);
    logic [31:0] ins, a, b, si, r, ea;
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd;
    ins = ref_mem[m_pc[11:2]];
    m_pc = m_pc + 32'd4;
    op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11]; fn = ins[5:0];
    a  = m_rf[rs];
    b  = m_rf[rt];
    si = {{16{ins[15]}}, ins[15:0]};
    ea = a + si;
    is_sw = 1'b0; wa = 32'd0; wd = 32'd0; base = -1; r = 32'd0;
    case (op)
      6'h00: begin
        base = 4;
        case (fn)
          6'h20: r = a + b;
          6'h22: r = a - b;
          6'h24: r = a & b;
          6'h25: r = a | b;
          6'h2A: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          default: base = -1;
        endcase
        if (rd != 5'd0) m_rf[rd] = r;
      end
      6'h08: begin base = 4; if (rt != 5'd0) m_rf[rt] = ea; end
      6'h23: begin base = 5; if (rt != 5'd0) m_rf[rt] = ref_mem[ea[11:2]]; end
      6'h2B: begin base = 4; ref_mem[ea[11:2]] = b; is_sw = 1'b1; wa = ea; wd = b; end
      6'h04: begin base = 3; if (a == b) m_pc = m_pc + (si << 2); end
      6'h02: begin base = 3; m_pc = {m_pc[31:28], ins[25:0], 2'b00}; end
      default: base = -1;
    endcase
  endtask

  // memory responder and retire monitor, sampled away from the rising edge
  initial begin
    mem_ready = 1'b0;
    mem_rdata = 32'd0;
    forever begin
      @(negedge Clk);
      if (mem_req) begin
        if (prev_wait) begin
          check_val("hold_addr", mem_addr, prev_addr);
          check_val("hold_we", {31'd0, mem_we}, {31'd0, prev_we});
          check_val("hold_wdata", mem_wdata, prev_wdata);
        end
        if (!got_first) begin first_req_addr = mem_addr; got_first = 1'b1; end
        if (fw_left > 0) begin mem_ready = 1'b0; fw_left--; end
        else if (hold_wr && mem_we) mem_ready = 1'b0;
        else mem_ready = ($urandom_range(99) >= wait_pct);
        mem_rdata = mem[mem_addr[11:2]];
        if (mem_ready && mem_we) begin
          mem[mem_addr[11:2]] = mem_wdata;
          last_wr_addr = mem_addr;
          last_wr_data = mem_wdata;
        end
        prev_wait  = !mem_ready;
        prev_addr  = mem_addr;
        prev_we    = mem_we;
        prev_wdata = mem_wdata;
      end else begin
        prev_wait = 1'b0;
        mem_ready = 1'($urandom_range(1));
        mem_rdata = $urandom;
      end
      #1;
      if (!Rst_n) begin
        cyc = 0; wcyc = 0; n_ret = 0; req_in_halt = 0; pc_pend = 1'b0;
        got_first = 1'b0; fw_left = force_wait; last_ret_cyc = 0;
        m_pc = RST_PC;
        for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
      end else begin
        cyc++;
        if (mem_req && !mem_ready) wcyc++;
        if (halted && mem_req) req_in_halt++;
        if (pc_pend) begin
          check_val("pc_after_retire", pc_out, pc_exp);
          pc_pend = 1'b0;
        end
        if (retire) begin
          model_step(st_base, st_sw, st_wa, st_wd);
          n_ret++;
          last_ret_cyc = cyc;
          check_val("insn_cycles", cyc, st_base + wcyc);
          if (st_sw) begin
            check_val("sw_addr", last_wr_addr, st_wa);
            check_val("sw_data", last_wr_data, st_wd);
          end
          pc_exp  = m_pc;
          pc_pend = 1'b1;
          cyc = 0;
          wcyc = 0;
        end
      end
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = HALT_W;
  endtask

  task automatic sync_ref();
    ref_mem = mem;
  endtask

  task automatic do_reset();
    Rst_n = 1'b0;
    repeat (2) @(posedge Clk);
    #2 Rst_n = 1'b1;
  endtask

  task automatic run_to_halt(input int max_cyc);
    int n;
    n = 0;
    while (!halted && n < max_cyc) begin
      @(negedge Clk);
      n++;
    end
    repeat (4) @(negedge Clk);
    #2;
    check_val("halt_reached", {31'd0, halted}, 32'd1);
    check_val("halt_pc", pc_out, m_pc + 32'd4);
    check_val("halt_no_req", req_in_halt, 32'd0);
    for (int i = 0; i < 32; i++)
      check_val($sformatf("reg_r%0d", i), dut.rf_q[i], m_rf[i]);
  endtask

  task automatic gen_random_prog(input int n);
    logic [5:0] fns [5];
    logic [31:0] w;
    logic [4:0] rs, rt, rd;
    int k;
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    clear_mem();
    for (int i = 512; i < 576; i++) mem[i] = $urandom;
    for (int i = 0; i < n; i++) begin
      rs = 5'($urandom_range(7));
      rt = 5'($urandom_range(7));
      rd = 5'($urandom_range(7));
      k  = $urandom_range(9);
      case (k)
        2, 3:    w = enc_i(6'h08, rt, rs, 16'($urandom));
        4:       w = enc_i(6'h23, rt, 5'd0, 16'(32'h800 + 4 * $urandom_range(63)));
        5:       w = enc_i(6'h2B, rt, 5'd0, 16'(32'h800 + 4 * $urandom_range(63)));
        6:       w = enc_i(6'h04, 5'(rt % 4), 5'(rs % 4), 16'($urandom_range(3)));
        7:       w = enc_j(26'(16 + i + 1 + $urandom_range(3)));
        default: w = enc_r(fns[$urandom_range(4)], rd, rs, rt);
      endcase
      mem[16 + i] = w;
    end
    sync_ref();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // reset then fetch: addi r1,r0,5
    clear_mem();
    mem[16] = enc_i(6'h08, 5'd1, 5'd0, 16'd5);
    sync_ref();
    wait_pct = 0; force_wait = 0;
    #13;
    check_val("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check_val("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check_val("rst_mem_addr", mem_addr, 32'd0);
    check_val("rst_mem_wdata", mem_wdata, 32'd0);
    check_val("rst_retire", {31'd0, retire}, 32'd0);
    check_val("rst_halted", {31'd0, halted}, 32'd0);
    check_val("rst_pc", pc_out, RST_PC);
    do_reset();
    run_to_halt(100);
    check_val("t1_first_addr", first_req_addr, 32'h40);
    check_val("t1_retires", n_ret, 32'd1);
    check_val("t1_retire_cyc", last_ret_cyc, 32'd4);
    check_val("t1_r1", dut.rf_q[1], 32'd5);

    // three wait cycles on the fetch
    force_wait = 3;
    do_reset();
    run_to_halt(100);
    force_wait = 0;
    check_val("t2_retire_cyc", last_ret_cyc, 32'd7);
    check_val("t2_r1", dut.rf_q[1], 32'd5);

    // load/store
    clear_mem();
    mem[512] = 32'hDEAD_BEEF;
    mem[16] = enc_i(6'h23, 5'd3, 5'd0, 16'h0800);
    mem[17] = enc_i(6'h08, 5'd2, 5'd0, 16'h0100);
    mem[18] = enc_i(6'h2B, 5'd3, 5'd2, 16'd8);
    mem[19] = enc_i(6'h23, 5'd4, 5'd2, 16'd8);
    sync_ref();
    do_reset();
    run_to_halt(200);
    check_val("t3_sw_addr", last_wr_addr, 32'h108);
    check_val("t3_sw_data", last_wr_data, 32'hDEAD_BEEF);
    check_val("t3_lw_cyc", last_ret_cyc, 32'd5);
    check_val("t3_r4", dut.rf_q[4], 32'hDEAD_BEEF);

    // beq r0,r0,-1 at 0x10 loops on itself
    clear_mem();
    mem[16] = enc_j(26'd4);
    mem[4]  = enc_i(6'h04, 5'd0, 5'd0, 16'hFFFF);
    sync_ref();
    do_reset();
    repeat (40) @(negedge Clk);
    #2;
    check_val("t4_loop_retires", {31'd0, n_ret >= 8}, 32'd1);
    check_val("t4_not_halted", {31'd0, halted}, 32'd0);

    // j 0x40 lands at 0x100, untaken and taken beq
    clear_mem();
    mem[16] = 32'h0800_0040;
    mem[64] = enc_i(6'h08, 5'd1, 5'd0, 16'd1);
    mem[65] = enc_i(6'h04, 5'd0, 5'd1, 16'd5);
    mem[66] = enc_i(6'h04, 5'd0, 5'd0, 16'd1);
    mem[67] = enc_i(6'h08, 5'd5, 5'd0, 16'd99);
    mem[68] = enc_i(6'h08, 5'd6, 5'd0, 16'd7);
    sync_ref();
    do_reset();
    run_to_halt(200);
    check_val("t5_r5_skipped", dut.rf_q[5], 32'd0);
    check_val("t5_r6", dut.rf_q[6], 32'd7);
    check_val("t5_halt_pc", pc_out, 32'h118);

    // ALU edges
    clear_mem();
    mem[512] = 32'h7FFF_FFFF;
    mem[16] = enc_i(6'h23, 5'd1, 5'd0, 16'h0800);
    mem[17] = enc_i(6'h08, 5'd2, 5'd1, 16'd1);
    mem[18] = enc_i(6'h08, 5'd3, 5'd0, 16'hFFFF);
    mem[19] = enc_i(6'h08, 5'd4, 5'd0, 16'd1);
    mem[20] = enc_r(6'h2A, 5'd5, 5'd3, 5'd4);
    mem[21] = enc_r(6'h20, 5'd0, 5'd1, 5'd1);
    mem[22] = enc_r(6'h22, 5'd6, 5'd0, 5'd4);
    mem[23] = enc_r(6'h24, 5'd7, 5'd3, 5'd1);
    mem[24] = enc_r(6'h25, 5'd8, 5'd2, 5'd4);
    mem[25] = enc_r(6'h2A, 5'd9, 5'd4, 5'd3);
    sync_ref();
    do_reset();
    run_to_halt(300);
    check_val("t6_add_wrap", dut.rf_q[2], 32'h8000_0000);
    check_val("t6_slt_signed", dut.rf_q[5], 32'd1);
    check_val("t6_r0_zero", dut.rf_q[0], 32'd0);
    check_val("t6_sub_wrap", dut.rf_q[6], 32'hFFFF_FFFF);

    // reset asserted mid-MEM, then halt on opcode 0x3F
    clear_mem();
    mem[16] = enc_i(6'h2B, 5'd0, 5'd0, 16'h0800);
    mem[512] = 32'h1234_5678;
    sync_ref();
    hold_wr = 1'b1;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (mem_we) break;
    end
    check_val("t7_in_mem", {31'd0, mem_we}, 32'd1);
    #3 Rst_n = 1'b0;
    #1;
    check_val("t7_req_drop", {31'd0, mem_req}, 32'd0);
    check_val("t7_pc_reset", pc_out, RST_PC);
    hold_wr = 1'b0;
    do_reset();
    @(negedge Clk);
    #2;
    check_val("t7_restart_req", {31'd0, mem_req}, 32'd1);
    check_val("t7_restart_addr", mem_addr, RST_PC);
    run_to_halt(100);
    check_val("t7_stored", mem[512], 32'd0);

    // random forward-only programs with random wait states
    wait_pct = 30;
    for (int p = 0; p < 8; p++) begin
      gen_random_prog(30);
      do_reset();
      run_to_halt(3000);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
